// File: rtl/disp_pkg.sv
// Shared types and select encodings for the display-mode controller.
package disp_pkg;

  typedef enum logic [1:0] {
    MODE_HEX = 2'b00,
    MODE_BIN = 2'b01,
    MODE_DEC = 2'b10
  } mode_e;

  localparam logic [2:0] SEL_HEX   = 3'b001;
  localparam logic [2:0] SEL_BIN   = 3'b010;
  localparam logic [2:0] SEL_DEC   = 3'b100;
  localparam logic [2:0] SEL_BLANK = 3'b000;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_HEX: next_mode = MODE_BIN;
      MODE_BIN: next_mode = MODE_DEC;
      default:  next_mode = MODE_HEX;
    endcase
  endfunction

  function automatic logic [2:0] mode_sel(input mode_e m);
    case (m)
      MODE_HEX: mode_sel = SEL_HEX;
      MODE_BIN: mode_sel = SEL_BIN;
      MODE_DEC: mode_sel = SEL_DEC;
      default:  mode_sel = SEL_HEX;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, consecutive-cycle debounce and a one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d, db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only survives while the synchronised input keeps disagreeing.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level = db_q;
  assign rise  = db_q & ~db_dly_q;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display-mode sequencer: button (and optionally a timer, macro AUTO_CYCLE_EN) steps
// HEX->BIN->DEC with a blanking window of sel=000 around every change.
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_CYCLES    = 4,
  parameter int AUTO_PERIOD     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic [1:0] mode,
  output logic       blanking,
  output logic       mode_changed,
  output logic       dbg_state
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          blank_q, blank_d;
  logic          chg_q, chg_d;
  logic          press_evt, advance;
  logic          db_level_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .level (db_level_unused),
    .rise  (press_evt)
  );

`ifdef AUTO_CYCLE_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

  logic [AW-1:0] atimer_q, atimer_d;
  logic          auto_tick;

  assign auto_tick = (state_q == ST_SHOW) && auto_en && (atimer_q == AUTO_LAST);
  assign atimer_d  = ((state_q != ST_SHOW) || !auto_en || press_evt || auto_tick)
                     ? '0 : atimer_q + 1'b1;
  // A coincident press and tick collapse into one advance through this OR.
  assign advance   = press_evt | auto_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) atimer_q <= '0;
    else     atimer_q <= atimer_d;
  end
`else
  logic auto_en_unused;
  assign auto_en_unused = auto_en;
  assign advance        = press_evt;
`endif

  // Presses arriving in ST_BLANK are ignored, not queued.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bcnt_d  = bcnt_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    chg_d   = 1'b0;
    unique case (state_q)
      ST_SHOW: begin
        if (advance) begin
          mode_d  = next_mode(mode_q);
          bcnt_d  = '0;
          state_d = ST_BLANK;
          sel_d   = SEL_BLANK;
          blank_d = 1'b1;
        end else begin
          sel_d   = mode_sel(mode_q);
          blank_d = 1'b0;
        end
      end
      ST_BLANK: begin
        if (bcnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          sel_d   = mode_sel(mode_q);
          blank_d = 1'b0;
          chg_d   = 1'b1;
        end else begin
          bcnt_d  = bcnt_q + 1'b1;
          sel_d   = SEL_BLANK;
          blank_d = 1'b1;
        end
      end
      default: state_d = ST_SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SHOW;
      mode_q  <= MODE_HEX;
      bcnt_q  <= '0;
      sel_q   <= SEL_HEX;
      blank_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bcnt_q  <= bcnt_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      chg_q   <= chg_d;
    end
  end

  assign {s2, s1, s0}  = sel_q;
  assign mode          = mode_q;
  assign blanking      = blank_q;
  assign mode_changed  = chg_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: cycle reference model, press table, corner sequences, random bursts.
module tb_disp_mode_ctrl;

  localparam int DEB  = 16;
  localparam int BLK  = 4;
  localparam int APER = 64;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next, auto_en;
  logic       s0, s1, s2, blanking, mode_changed, st_dbg;
  logic [1:0] mode;

  logic       btn_b, auto_en_b;
  logic       b_s0, b_s1, b_s2, b_blanking, b_mode_changed, b_st_dbg;
  logic [1:0] b_mode;

  always #5 clk = ~clk;

  disp_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLANK_CYCLES(BLK), .AUTO_PERIOD(APER)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .auto_en(auto_en),
    .s0(s0), .s1(s1), .s2(s2), .mode(mode), .blanking(blanking),
    .mode_changed(mode_changed), .dbg_state(st_dbg)
  );

  // Long blank window so a second debounced press can land inside it.
  disp_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLANK_CYCLES(60), .AUTO_PERIOD(APER)) dut_b (
    .clk(clk), .rst(rst), .btn_next(btn_b), .auto_en(auto_en_b),
    .s0(b_s0), .s1(b_s1), .s2(b_s2), .mode(b_mode), .blanking(b_blanking),
    .mode_changed(b_mode_changed), .dbg_state(b_st_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int b_chg_cnt = 0;
  int chg_cnt   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delay line for the synchroniser, run-length debounce,
  // countdown blank window; outputs as seen after each edge.
  bit m_s1, m_s2, m_db, m_dbp, m_rise, m_chg;
  int m_run, m_mode, m_blank_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_chg = 0;
      m_run = 0; m_mode = 0; m_blank_left = 0;
    end else begin
      m_rise = m_db && !m_dbp;
      m_chg  = 0;
      if (m_blank_left == 0) begin
        if (m_rise) begin
          m_mode       = (m_mode + 1) % 3;
          m_blank_left = BLK;
        end
      end else begin
        m_blank_left--;
        if (m_blank_left == 0) m_chg = 1;
      end
      m_dbp = m_db;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_next;
    end
  end

  function automatic logic [6:0] model_vec();
    logic [2:0] sel;
    sel = (m_blank_left != 0) ? 3'b000 : (3'b001 << m_mode);
    return {sel, 2'(m_mode), (m_blank_left != 0), m_chg};
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("cycle_model", {9'b0, s2, s1, s0, mode, blanking, mode_changed},
                      {9'b0, model_vec()});
  end

  always @(posedge clk) begin
    #1;
    if (b_mode_changed) b_chg_cnt++;
    if (mode_changed)   chg_cnt++;
  end

  // ---------------- driver helpers ----------------
  task automatic press(input int hold, input int gap);
    @(negedge clk) btn_next = 1'b1;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_chg(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!mode_changed && cycles < 300);
  endtask

  typedef struct {
    int         hold;
    int         gap;
    logic [1:0] exp_mode;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[5];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [1:0] frozen;

    vecs[0] = '{30, 40, 2'b10, 3'b100};
    vecs[1] = '{30, 40, 2'b00, 3'b001};
    vecs[2] = '{30, 40, 2'b01, 3'b010};
    vecs[3] = '{10, 40, 2'b01, 3'b010};
    vecs[4] = '{ 3, 40, 2'b01, 3'b010};

    rst = 1'b1; btn_next = 1'b0; auto_en = 1'b0; btn_b = 1'b0; auto_en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {s2, s1, s0, mode, blanking, mode_changed}, {3'b001, 2'b00, 1'b0, 1'b0});
    @(negedge clk) rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {s2, s1, s0, mode, blanking}, {3'b001, 2'b00, 1'b0});

    // Single press: blank after edge 19, 4 blank cycles, pulse on new select.
    @(negedge clk) btn_next = 1'b1;
    repeat (18) @(posedge clk);
    #1 check("edge18_still_hex", {s2, s1, s0}, 3'b001);
    @(posedge clk); #1;
    check("edge19_blank", {s2, s1, s0, blanking}, {3'b000, 1'b1});
    check("edge19_mode_target", mode, 2'b01);
    repeat (3) @(posedge clk);
    #1 check("edge22_blank", {s2, s1, s0, blanking}, {3'b000, 1'b1});
    @(posedge clk); #1;
    check("edge23_bin_pulse", {s2, s1, s0, mode, blanking, mode_changed}, {3'b010, 2'b01, 1'b0, 1'b1});
    @(posedge clk); #1;
    check("edge24_pulse_end", mode_changed, 1'b0);
    repeat (40) @(posedge clk);
    #1 check("held_no_repeat", {s2, s1, s0, mode}, {3'b010, 2'b01});
    @(negedge clk) btn_next = 1'b0;
    repeat (40) @(negedge clk);

    // Table: clean presses wrap, short glitches ignored.
    foreach (vecs[i]) begin
      press(vecs[i].hold, vecs[i].gap);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
      check($sformatf("vec%0d_sel", i), {s2, s1, s0}, vecs[i].exp_sel);
    end

    // Reset in the second blank cycle.
    @(negedge clk) btn_next = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!blanking && n < 60);
    check("reach_blank_timeout", (n < 60), 1'b1);
    @(posedge clk);
    #2 rst = 1'b1; btn_next = 1'b0;
    #1 check("async_reset_midblank", {s2, s1, s0, mode, blanking, mode_changed},
             {3'b001, 2'b00, 1'b0, 1'b0});
    @(negedge clk) rst = 1'b0;
    chg_cnt = 0;
    repeat (40) @(posedge clk);
    #1 check("no_pulse_after_reset", chg_cnt, 0);
    check("mode_after_reset", {s2, s1, s0, mode}, {3'b001, 2'b00});

    // Second debounced press lands inside the long blank of dut_b.
    b_chg_cnt = 0;
    @(negedge clk) btn_b = 1'b1;
    repeat (20) @(negedge clk);
    btn_b = 1'b0;
    repeat (20) @(negedge clk);
    btn_b = 1'b1;
    repeat (25) @(negedge clk);
    btn_b = 1'b0;
    repeat (150) @(negedge clk);
    check("blank_drop_mode", b_mode, 2'b01);
    check("blank_drop_sel", {b_s2, b_s1, b_s0}, 3'b010);
    check("blank_drop_pulses", b_chg_cnt, 1);

    // Random button bursts against the model.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk) btn_next = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    btn_next = 1'b0;
    repeat (60) @(negedge clk);

`ifdef AUTO_CYCLE_EN
    chk_en = 1'b0;
    @(negedge clk) rst = 1'b1; auto_en = 1'b1;
    @(negedge clk) rst = 1'b0;
    wait_chg(n);
    check("auto_first_interval", n, 68);
    check("auto_sel1", {s2, s1, s0, mode}, {3'b010, 2'b01});
    wait_chg(n);
    check("auto_second_interval", n, 68);
    check("auto_sel2", {s2, s1, s0, mode}, {3'b100, 2'b10});
    wait_chg(n);
    check("auto_third_interval", n, 68);
    check("auto_sel3", {s2, s1, s0, mode}, {3'b001, 2'b00});
    @(negedge clk) auto_en = 1'b0;
    frozen = mode;
    chg_cnt = 0;
    repeat (200) @(negedge clk);
    check("auto_off_frozen", mode, frozen);
    check("auto_off_no_pulse", chg_cnt, 0);
`else
    frozen = mode;
    @(negedge clk) auto_en = 1'b1;
    repeat (150) @(negedge clk);
    auto_en = 1'b0;
    check("auto_ignored_mode", mode, frozen);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
